chunked_serial_adder: RTL and testbench

- Multi-cycle adder stage that reuses a CHUNK-bit ripple_carry_adder over N_BIT/CHUNK clock cycles, least-significant chunk first.
- The inter-chunk carry is registered between cycles.
- Sits in the adder datapath where area matters more than latency.
- Valid/ready handshakes on both sides let it drop between pipeline stages.

---
 rtl/adder_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 29 ++
 rtl/chunked_serial_adder.sv | 117 +++++++++++
 tb/tb_chunked_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and configuration helpers for the chunked serial adder.
package adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int unsigned calc_n_chunk(input int unsigned n_bit,
                                                input int unsigned chunk);
      return n_bit / chunk;
   endfunction

   // True when the width can be split evenly into chunks of at least two bits.
   function automatic bit chunk_cfg_ok(input int unsigned n_bit, input int unsigned chunk);
      return (chunk >= 2) && (chunk <= n_bit) && ((n_bit % chunk) == 0);
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder with carry-out and signed-overflow flags.
module ripple_carry_adder #(
   parameter int unsigned N_BIT = 8
) (
   input  logic [N_BIT-1:0] i_a,
   input  logic [N_BIT-1:0] i_b,
   input  logic             i_carry,
   output logic [N_BIT-1:0] o_sum,
   output logic             o_carry,
   output logic             o_overflow
);

   logic [N_BIT:0] w_c;

   always_comb begin
      w_c    = '0;
      o_sum  = '0;
      w_c[0] = i_carry;
      for (int i = 0; i < N_BIT; i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_carry    = w_c[N_BIT];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign o_overflow = w_c[N_BIT] ^ w_c[N_BIT-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: one CHUNK-bit ripple adder reused LSB chunk first, with
// valid/ready handshakes on both sides.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned N_BIT = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] operand_1,
   input  logic [N_BIT-1:0] operand_2,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned N_CHUNK = calc_n_chunk(N_BIT, CHUNK);
   localparam int unsigned CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNK - 1);

   if (!chunk_cfg_ok(N_BIT, CHUNK)) begin : g_bad_cfg
      $error("chunked_serial_adder: N_BIT must be a multiple of CHUNK and CHUNK >= 2");
   end

   state_t           r_state;
   state_t           w_next_state;
   logic [N_BIT-1:0] r_op1;
   logic [N_BIT-1:0] r_op2;
   logic [N_BIT-1:0] r_sum;
   logic [N_BIT-1:0] w_sum_next;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry_out;
   logic             r_overflow;
   logic [CHUNK-1:0] w_chunk_sum;
   logic             w_chunk_carry;
   logic             w_chunk_ovf;
   logic             w_last;

   ripple_carry_adder #(
      .N_BIT(CHUNK)
   ) u_rca (
      .i_a       (r_op1[CHUNK-1:0]),
      .i_b       (r_op2[CHUNK-1:0]),
      .i_carry   (r_carry),
      .o_sum     (w_chunk_sum),
      .o_carry   (w_chunk_carry),
      .o_overflow(w_chunk_ovf)
   );

   assign w_last    = (r_cnt == LAST_CNT);
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;

   // New chunk enters at the top so the LSB chunk ends up at the bottom.
   always_comb begin
      w_sum_next                   = r_sum >> CHUNK;
      w_sum_next[N_BIT-1 -: CHUNK] = w_chunk_sum;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next_state = RUN;
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op1       <= '0;
         r_op2       <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op1   <= operand_1;
                  r_op2   <= operand_2;
                  r_carry <= carry_in;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_sum   <= w_sum_next;
               r_op1   <= r_op1 >> CHUNK;
               r_op2   <= r_op2 >> CHUNK;
               r_carry <= w_chunk_carry;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_carry_out <= w_chunk_carry;
                  r_overflow  <= w_chunk_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: directed cases on a 32/8 instance, randomized traffic on a
// 16/4 instance, both against an arithmetic reference model.
module tb_chunked_serial_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        co;
      logic        ov;
   } res_t;

   logic clk;
   logic rst;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, cin_a, co_a, ov_a;
   logic [31:0] op1_a, op2_a, sum_a;
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, cin_b, co_b, ov_b;
   logic [15:0] op1_b, op2_b, sum_b;

   int n_checks = 0;
   int n_errors = 0;

   chunked_serial_adder #(.N_BIT(32), .CHUNK(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .operand_1(op1_a), .operand_2(op2_a), .carry_in(cin_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .sum(sum_a), .carry_out(co_a), .overflow(ov_a)
   );

   chunked_serial_adder #(.N_BIT(16), .CHUNK(4)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .operand_1(op1_b), .operand_2(op2_b), .carry_in(cin_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .sum(sum_b), .carry_out(co_b), .overflow(ov_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain wide addition, then truncate; signed overflow from operand/result signs.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input int w);
      logic [63:0] full;
      logic [63:0] mask;
      res_t        r;
      mask  = (64'd1 << w) - 64'd1;
      full  = {32'd0, a} + {32'd0, b} + {63'd0, cin};
      r.sum = 32'(full & mask);
      r.co  = full[w];
      r.ov  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_a(input logic [31:0] a, input logic [31:0] b, input logic cin);
      @(negedge clk);
      chk("in_ready before accept", 64'(in_ready_a), 64'd1);
      in_valid_a = 1'b1;
      op1_a      = a;
      op2_a      = b;
      cin_a      = cin;
      @(negedge clk);
      in_valid_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      int n;
      n = 0;
      while (!out_valid_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, " latency"}, 64'(n), 64'd4);
   endtask

   task automatic check_res_a(input string name, input logic [31:0] s, input logic co,
                              input logic ov);
      res_t m;
      m = model(op1_a, op2_a, cin_a, 32);
      chk({name, " model"}, {31'd0, m.sum, m.co, m.ov}, {31'd0, s, co, ov});
      chk({name, " dut"}, {31'd0, sum_a, co_a, ov_a}, {31'd0, s, co, ov});
   endtask

   task automatic handoff_a(input string name);
      out_ready_a = 1'b1;
      @(negedge clk);
      out_ready_a = 1'b0;
      chk({name, " out_valid after handoff"}, 64'(out_valid_a), 64'd0);
      chk({name, " in_ready after handoff"}, 64'(in_ready_a), 64'd1);
   endtask

   initial begin
      res_t q[$];
      res_t e;
      int   accepted;
      int   cyc;

      rst = 1'b1;
      in_valid_a = 0; out_ready_a = 0; op1_a = 0; op2_a = 0; cin_a = 0;
      in_valid_b = 0; out_ready_b = 0; op1_b = 0; op2_b = 0; cin_b = 0;
      #2;
      chk("reset outputs a", {sum_a, co_a, ov_a, out_valid_a, in_ready_a},
          {32'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      chk("reset outputs b", {sum_b, co_b, ov_b, out_valid_b, in_ready_b},
          {16'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Wrap to zero with carry out.
      start_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done_a("t1");
      check_res_a("t1", 32'h0000_0000, 1'b1, 1'b0);
      handoff_a("t1");

      // Signed overflow positive and negative.
      start_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done_a("t2a");
      check_res_a("t2a", 32'h8000_0000, 1'b0, 1'b1);
      handoff_a("t2a");
      start_a(32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_done_a("t2b");
      check_res_a("t2b", 32'h0000_0000, 1'b1, 1'b1);
      handoff_a("t2b");

      // Carry propagation across chunk boundaries with carry_in.
      start_a(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      wait_done_a("t3");
      check_res_a("t3", 32'h2222_2222, 1'b0, 1'b0);
      handoff_a("t3");

      // Backpressure: result held, new operands ignored.
      start_a(32'h1111_1111, 32'h2222_2222, 1'b0);
      wait_done_a("t4");
      check_res_a("t4", 32'h3333_3333, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid_a = 1'b1;
         op1_a      = $urandom;
         op2_a      = $urandom;
         @(negedge clk);
         chk("t4 hold", {sum_a, co_a, ov_a, out_valid_a, in_ready_a},
             {32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b0});
      end
      in_valid_a = 1'b0;
      handoff_a("t4");
      repeat (6) @(negedge clk);
      chk("t4 no stray capture", {out_valid_a, in_ready_a}, {1'b0, 1'b1});

      // Asynchronous reset on the second RUN cycle.
      start_a(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5 async reset", {sum_a, out_valid_a, in_ready_a}, {32'd0, 1'b0, 1'b1});
      @(negedge clk);
      rst = 1'b0;
      start_a(32'd5, 32'd3, 1'b0);
      wait_done_a("t5");
      check_res_a("t5", 32'd8, 1'b0, 1'b0);
      handoff_a("t5");

      // Randomized back-to-back traffic on the 16/4 instance.
      accepted = 0;
      cyc      = 0;
      while ((accepted < 10000 || q.size() > 0) && cyc < 90000) begin
         @(negedge clk);
         cyc++;
         out_ready_b = ($urandom_range(7) != 0);
         if (out_valid_b) begin
            if (q.size() == 0) begin
               chk("rand unexpected out_valid", 64'd1, 64'd0);
            end else begin
               e = q[0];
               chk("rand result", {co_b, ov_b, sum_b}, {e.co, e.ov, e.sum[15:0]});
               if (out_ready_b) void'(q.pop_front());
            end
         end
         if (accepted < 10000) begin
            in_valid_b = ($urandom_range(7) != 0);
            op1_b      = 16'($urandom);
            op2_b      = 16'($urandom);
            cin_b      = 1'($urandom);
            if (in_valid_b && in_ready_b) begin
               q.push_back(model({16'd0, op1_b}, {16'd0, op2_b}, cin_b, 16));
               accepted++;
            end
         end else begin
            in_valid_b = 1'b0;
         end
      end
      chk("rand cycle budget", 64'(cyc < 90000), 64'd1);
      chk("rand accepted", 64'(accepted), 64'd10000);
      chk("rand pending results", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
